// File: rtl/riscv_pkg.sv
// Shared types for the EX operand stage: operand-select encodings and the default datapath width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OPA_REG  = 2'd0,
    OPA_PC   = 2'd1,
    OPA_ZERO = 2'd2
  } opa_sel_e;

  typedef enum logic [1:0] {
    OPB_REG  = 2'd0,
    OPB_IMM  = 2'd1,
    OPB_FOUR = 2'd2
  } opb_sel_e;

endpackage

// File: rtl/opr_fwd_select.sv
// Priority forwarding select for one source register. Source 0 is the youngest
// producer and wins; register x0 is never forwarded.
module opr_fwd_select #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic [REG_AW-1:0]              addr,
  input  logic [XLEN-1:0]                rdata,
  input  logic [NUM_FWD-1:0]             fwd_valid,
  input  logic [NUM_FWD-1:0][REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]                value,
  output logic                           hit
);

  // Scan oldest to youngest so the lowest matching index is the last write.
  always_comb begin
    value = rdata;
    hit   = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[i] == addr) && (addr != '0)) begin
        value = fwd_data[i];
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// EX-input operand stage: forwards rs1/rs2, muxes ALU operands A/B and registers
// them (plus store data) into a valid/ready register feeding the ALU.
// Optional: define ALU_OPR_PERF_EN to add saturating forwarded-operand counters.
module alu_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [REG_AW-1:0]              rs1_addr,
  input  logic [REG_AW-1:0]              rs2_addr,
  input  logic [XLEN-1:0]                rdata1,
  input  logic [XLEN-1:0]                rdata2,
  input  logic [XLEN-1:0]                pc_in,
  input  logic [XLEN-1:0]                imm_in,
  input  opa_sel_e                       opa_sel,
  input  opb_sel_e                       opb_sel,
  input  logic [NUM_FWD-1:0]             fwd_valid,
  input  logic [NUM_FWD-1:0][REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                opr_a,
  output logic [XLEN-1:0]                opr_b,
`ifdef ALU_OPR_PERF_EN
  output logic [31:0]                    fwd_cnt_a,
  output logic [31:0]                    fwd_cnt_b,
`endif
  output logic [XLEN-1:0]                store_data
);

  // Index 0 = rs1, 1 = rs2.
  logic [1:0][REG_AW-1:0] src_addr;
  logic [1:0][XLEN-1:0]   src_rdata;
  logic [1:0][XLEN-1:0]   src_val;
  logic [1:0]             src_hit;

  assign src_addr  = {rs2_addr, rs1_addr};
  assign src_rdata = {rdata2, rdata1};

  for (genvar s = 0; s < 2; s++) begin : g_src
    opr_fwd_select #(
      .XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)
    ) u_fwd (
      .addr     (src_addr[s]),
      .rdata    (src_rdata[s]),
      .fwd_valid(fwd_valid),
      .fwd_rd   (fwd_rd),
      .fwd_data (fwd_data),
      .value    (src_val[s]),
      .hit      (src_hit[s])
    );
  end

  logic [XLEN-1:0] a_nxt, b_nxt;
  logic            load;

  // Operand muxes; unknown encodings yield zero.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    case (opa_sel)
      OPA_REG:  a_nxt = src_val[0];
      OPA_PC:   a_nxt = pc_in;
      default:  a_nxt = '0;
    endcase
    case (opb_sel)
      OPB_REG:  b_nxt = src_val[1];
      OPB_IMM:  b_nxt = imm_in;
      OPB_FOUR: b_nxt = XLEN'(4);
      default:  b_nxt = '0;
    endcase
  end

  // A flush cycle refuses new input so nothing sneaks past the kill.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;

  // Valid bit: flush wins, otherwise follow in_valid whenever the slot is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out_valid <= 1'b0;
    else if (flush)    out_valid <= 1'b0;
    else if (in_ready) out_valid <= in_valid;
  end

  // Operand register captures forwarded values only at the load edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opr_a      <= '0;
      opr_b      <= '0;
      store_data <= '0;
    end else if (load) begin
      opr_a      <= a_nxt;
      opr_b      <= b_nxt;
      store_data <= src_val[1];
    end
  end

`ifdef ALU_OPR_PERF_EN
  logic inc_a, inc_b;
  assign inc_a = load && (opa_sel == OPA_REG) && src_hit[0];
  assign inc_b = load && (opb_sel == OPB_REG) && src_hit[1];

  // Saturating forwarded-operand counters; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt_a <= '0;
      fwd_cnt_b <= '0;
    end else begin
      if (inc_a && (fwd_cnt_a != '1)) fwd_cnt_a <= fwd_cnt_a + 32'd1;
      if (inc_b && (fwd_cnt_b != '1)) fwd_cnt_b <= fwd_cnt_b + 32'd1;
    end
  end
`else
  logic unused_hits;
  assign unused_hits = ^src_hit;
`endif

endmodule
